// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage.
// Issues aligned, byte-enabled req/ack accesses and extends load data.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] RD,
    output logic        Stall,
    output logic        MisalignedFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAULT
    } state_t;

    state_t      state;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic        access;
    logic        illegal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign access = MemRead | MemWrite;

    // Stall covers the issuing IDLE cycle and every REQ cycle.
    assign Stall = ((state == IDLE) & access) | (state == REQ);

    // Decode size into lane enables and replicated store data; flag illegal accesses.
    always_comb begin
        illegal    = MemRead & MemWrite;
        be_next    = 4'b0000;
        wdata_next = WriteData;
        case (funct3)
            3'b000, 3'b100: begin
                be_next    = 4'b0001 << ALUResult[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            3'b001, 3'b101: begin
                be_next    = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{WriteData[15:0]}};
                if (ALUResult[0]) illegal = 1'b1;
            end
            3'b010: begin
                be_next = 4'b1111;
                if (ALUResult[1:0] != 2'b00) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (MemWrite && funct3[2]) illegal = 1'b1;
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Access FSM with registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            RD              <= 32'd0;
            MisalignedFault <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'd0;
            mem_be          <= 4'd0;
            mem_wdata       <= 32'd0;
            lat_f3          <= 3'd0;
            lat_off         <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && illegal) begin
                        MisalignedFault <= 1'b1;
                        state           <= FAULT;
                    end else if (access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {ALUResult[31:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= wdata_next;
                        lat_f3    <= funct3;
                        lat_off   <= ALUResult[1:0];
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_be  <= 4'd0;
                        if (!mem_we) RD <= ld_data;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    MisalignedFault <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a queue scoreboard.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] RD;
    logic        Stall;
    logic        MisalignedFault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        logic        fault;
        logic [31:0] rd;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd;

    load_store_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .funct3(funct3),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .RD(RD),
        .Stall(Stall),
        .MisalignedFault(MisalignedFault),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: new requests, request stability, completions, faults.
    logic        prev_req = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    logic        p_we;

    always @(negedge clk) begin
        req_t r;
        rsp_t s;
        if (!rst_n) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", mem_addr, r.addr);
                    chk("req_be", {28'd0, mem_be}, {28'd0, r.be});
                    chk("req_wdata", mem_wdata, r.wdata);
                    chk("req_we", {31'd0, mem_we}, {31'd0, r.we});
                end
            end else if (mem_req && prev_req) begin
                chk("stable_addr", mem_addr, p_addr);
                chk("stable_wdata", mem_wdata, p_wdata);
                chk("stable_be_we", {27'd0, mem_be, mem_we},
                    {27'd0, p_be, p_we});
            end
            if (prev_done || MisalignedFault) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    s = rsp_q.pop_front();
                    chk("rsp_kind", {31'd0, MisalignedFault},
                        {31'd0, s.fault});
                    chk("rsp_rd", RD, s.rd);
                    chk("rsp_stall", {31'd0, Stall}, 32'd0);
                    chk("rsp_noreq", {31'd0, mem_req}, 32'd0);
                end
            end
            prev_req  = mem_req;
            prev_done = mem_req && mem_ack;
            p_addr    = mem_addr;
            p_wdata   = mem_wdata;
            p_be      = mem_be;
            p_we      = mem_we;
        end
    end

    // Legal access: pushes expectations, acks after 'waits' cycles.
    task automatic access(input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int waits, input logic [3:0] be,
                          input logic [31:0] ewd, input logic [31:0] erd);
        int n;
        req_t q;
        rsp_t s;
        q.addr = {a[31:2], 2'b00};
        q.be = be;
        q.wdata = ewd;
        q.we = w;
        req_q.push_back(q);
        exp_rd = erd;
        s.fault = 1'b0;
        s.rd = erd;
        rsp_q.push_back(s);
        n = 0;
        @(posedge clk) #1;
        MemRead = r;
        MemWrite = w;
        funct3 = f3;
        ALUResult = a;
        WriteData = wd;
        @(negedge clk) if (Stall) n++;
        @(posedge clk) #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            mem_ack = (i == waits);
            mem_rdata = (i == waits) ? rdat : 32'hBAD0_BAD0;
            @(negedge clk) if (Stall) n++;
            @(posedge clk) #1;
        end
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk) if (Stall) n++;
        chk("stall_cycles", n, waits + 2);
    endtask

    // Illegal access: expects one stall cycle then a fault pulse.
    task automatic bad(input logic r, input logic w,
                       input logic [2:0] f3, input logic [31:0] a);
        int n;
        rsp_t s;
        s.fault = 1'b1;
        s.rd = exp_rd;
        rsp_q.push_back(s);
        n = 0;
        @(posedge clk) #1;
        MemRead = r;
        MemWrite = w;
        funct3 = f3;
        ALUResult = a;
        @(negedge clk) if (Stall) n++;
        @(posedge clk) #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk) if (Stall) n++;
        @(posedge clk) #1;
        @(negedge clk) begin
            if (Stall) n++;
            chk("fault_pulse_end", {31'd0, MisalignedFault}, 32'd0);
        end
        chk("fault_stall", n, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        MemRead = 1'b1;
        MemWrite = 1'b0;
        funct3 = 3'b010;
        ALUResult = 32'h400;
        WriteData = 32'd0;
        mem_ack = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        exp_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", RD, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_fault", {31'd0, MisalignedFault}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;

        // r w f3 addr wdata rdata waits be ewdata erd
        access(1, 0, 3'b010, 32'h400, 32'h0, 32'h1122_3344, 0,
               4'b1111, 32'h0, 32'h1122_3344);
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0,
               4'b1000, 32'h0, 32'h0000_0080);
        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 0,
               4'b1100, 32'h0, 32'hFFFF_80FF);
        access(0, 1, 3'b000, 32'h201, 32'h1234_56AB, 32'hFFFF_FFFF, 0,
               4'b0010, 32'hABAB_ABAB, 32'hFFFF_80FF);
        access(0, 1, 3'b001, 32'h202, 32'h1234_56AB, 32'h0, 1,
               4'b1100, 32'h56AB_56AB, 32'hFFFF_80FF);
        access(0, 1, 3'b010, 32'h304, 32'hCAFE_F00D, 32'h0, 0,
               4'b1111, 32'hCAFE_F00D, 32'hFFFF_80FF);
        access(1, 0, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 3,
               4'b1111, 32'h0, 32'hDEAD_BEEF);
        access(1, 0, 3'b101, 32'h300, 32'h0, 32'h1234_F00D, 0,
               4'b0011, 32'h0, 32'h0000_F00D);
        access(1, 0, 3'b000, 32'h101, 32'h0, 32'h0000_F000, 2,
               4'b0010, 32'h0, 32'hFFFF_FFF0);
        access(1, 0, 3'b100, 32'h102, 32'h0, 32'h0077_0000, 0,
               4'b0100, 32'h0, 32'h0000_0077);

        bad(1, 0, 3'b010, 32'h002);
        bad(1, 0, 3'b011, 32'h000);
        bad(1, 1, 3'b010, 32'h000);
        bad(0, 1, 3'b100, 32'h000);
        bad(1, 0, 3'b001, 32'h101);
        bad(1, 0, 3'b110, 32'h000);

        // Abort a load in REQ with reset.
        begin
            req_t q;
            q.addr = 32'h500;
            q.be = 4'b1111;
            q.wdata = 32'h0;
            q.we = 1'b0;
            req_q.push_back(q);
        end
        @(posedge clk) #1;
        MemRead = 1'b1;
        funct3 = 3'b010;
        ALUResult = 32'h500;
        @(posedge clk) #1;
        MemRead = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_rd", RD, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_stall", {31'd0, Stall}, 32'd0);
        chk("abort_idle_req", {31'd0, mem_req}, 32'd0);
        exp_rd = 32'd0;
        access(1, 0, 3'b001, 32'h602, 32'h0, 32'h7FFF_0000, 0,
               4'b1100, 32'h0, 32'h0000_7FFF);

        repeat (3) @(posedge clk);
        chk("req_q_empty", req_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
